// File: rtl/gated_and_tester_pkg.sv
// Shared definitions for the gated-AND self-test initiator: state encoding,
// last-vector constant and the reference function f = a ? (b & c) : c.
package gated_and_tester_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETTLE = ST_SETTLE,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_e;

    localparam logic [2:0] VEC_LAST = 3'd7;

    // Expected response of the gated-AND block for one input vector.
    function automatic logic exp_f(input logic a, input logic b, input logic c);
        return a ? (b & c) : c;
    endfunction

endpackage

// File: rtl/gated_and_tester_ref.sv
// Combinational reference model of the gated-AND block (a,b,c -> exp_f),
// used by the tester to compute the value it expects on each vector.
module gated_and_ref
    import gated_and_tester_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_exp_f
);

    assign o_exp_f = exp_f(i_a, i_b, i_c);

endmodule

// File: rtl/gated_and_tester.sv
// Self-test initiator for the gated-AND block. Sweeps all eight {a,b,c}
// vectors PASSES times, holds each for SETTLE_CYCLES before sampling f,
// counts mismatches (saturating) and reports through a start/done handshake.
// Optional first-failure capture: define GATED_AND_TESTER_FAIL_CAPTURE_EN to
// add the o_fail_vec / o_fail_vld ports and their logic.
module gated_and_tester
    import gated_and_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_dut_a,
    output logic             o_dut_b,
    output logic             o_dut_c,
    input  logic             i_dut_f,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
    ,
    output logic [2:0]       o_fail_vec,
    output logic             o_fail_vld
`endif
);

    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_ZERO  = {ERR_W{1'b0}};

    state_e              r_state;
    state_e              w_state_nxt;
    logic [SET_W-1:0]    r_settle;
    logic [SET_W-1:0]    w_settle_nxt;
    logic [2:0]          r_vec;
    logic [2:0]          w_vec_nxt;
    logic [PASS_W-1:0]   r_pass_idx;
    logic [PASS_W-1:0]   w_pass_idx_nxt;
    logic [ERR_W-1:0]    r_err;
    logic [ERR_W-1:0]    w_err_nxt;
    logic                r_pass;
    logic                w_pass_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_exp_f;
    logic                w_mismatch;
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
    logic [2:0]          r_fail_vec;
    logic [2:0]          w_fail_vec_nxt;
    logic                r_fail_vld;
    logic                w_fail_vld_nxt;
`endif

    // Reference for the vector currently being driven; vector index is {a,b,c}.
    gated_and_ref u_ref (
        .i_a     (r_vec[2]),
        .i_b     (r_vec[1]),
        .i_c     (r_vec[0]),
        .o_exp_f (w_exp_f)
    );

    assign w_mismatch = (i_dut_f != w_exp_f);

    // Next-state, counter and status logic for the sweep sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_settle_nxt   = r_settle;
        w_vec_nxt      = r_vec;
        w_pass_idx_nxt = r_pass_idx;
        w_err_nxt      = r_err;
        w_pass_nxt     = r_pass;
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
        w_fail_vec_nxt = r_fail_vec;
        w_fail_vld_nxt = r_fail_vld;
`endif
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_vec_nxt      = 3'd0;
                    w_pass_idx_nxt = {PASS_W{1'b0}};
                    w_err_nxt      = ERR_ZERO;
                    w_pass_nxt     = 1'b0;
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
                    w_fail_vld_nxt = 1'b0;
`endif
                    w_settle_nxt   = SET_LOAD;
                    w_state_nxt    = SETTLE;
                end else begin
                    w_vec_nxt      = 3'd0;
                end
            end
            SETTLE: begin
                w_settle_nxt = r_settle - SET_W'(1);
                if (r_settle == SET_W'(1)) begin
                    w_state_nxt = SAMPLE;
                end else begin
                    w_state_nxt = SETTLE;
                end
            end
            SAMPLE: begin
                // The mismatch that reaches all-ones is itself counted.
                if (w_mismatch) begin
                    if (r_err != ERR_MAX) begin
                        w_err_nxt = r_err + ERR_W'(1);
                    end else begin
                        w_err_nxt = r_err;
                    end
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
                    if (!r_fail_vld) begin
                        w_fail_vec_nxt = r_vec;
                        w_fail_vld_nxt = 1'b1;
                    end else begin
                        w_fail_vec_nxt = r_fail_vec;
                        w_fail_vld_nxt = r_fail_vld;
                    end
`endif
                end else begin
                    w_err_nxt = r_err;
                end
                if ((r_vec == VEC_LAST) && (r_pass_idx == PASS_LAST)) begin
                    // Verdict registered on entry to DONE so it is valid with the done pulse.
                    w_pass_nxt  = (w_err_nxt == ERR_ZERO);
                    w_state_nxt = DONE;
                end else begin
                    w_vec_nxt = r_vec + 3'd1;
                    if (r_vec == VEC_LAST) begin
                        w_pass_idx_nxt = r_pass_idx + PASS_W'(1);
                    end else begin
                        w_pass_idx_nxt = r_pass_idx;
                    end
                    w_settle_nxt = SET_LOAD;
                    w_state_nxt  = SETTLE;
                end
            end
            DONE: begin
                w_vec_nxt   = 3'd0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_vec_nxt   = 3'd0;
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (w_state_nxt == DONE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_settle   <= {SET_W{1'b0}};
            r_vec      <= 3'd0;
            r_pass_idx <= {PASS_W{1'b0}};
            r_err      <= ERR_ZERO;
            r_pass     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
            r_fail_vec <= 3'd0;
            r_fail_vld <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_settle   <= w_settle_nxt;
            r_vec      <= w_vec_nxt;
            r_pass_idx <= w_pass_idx_nxt;
            r_err      <= w_err_nxt;
            r_pass     <= w_pass_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
            r_fail_vec <= w_fail_vec_nxt;
            r_fail_vld <= w_fail_vld_nxt;
`endif
        end
    end

    assign o_dut_a   = r_vec[2];
    assign o_dut_b   = r_vec[1];
    assign o_dut_c   = r_vec[0];
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_pass    = r_pass;
    assign o_err_cnt = r_err;
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
    assign o_fail_vec = r_fail_vec;
    assign o_fail_vld = r_fail_vld;
`endif

endmodule

// File: tb/tb_gated_and_tester.sv
// Self-checking bench for gated_and_tester. Three tester instances with
// different SETTLE_CYCLES/PASSES/ERR_W each drive a stand-in function block
// whose response is the true gated-AND value XOR a per-instance fault mask.
module tb_gated_and_tester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st    [3];
    logic       a     [3];
    logic       b     [3];
    logic       c     [3];
    logic       f     [3];
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [7:0] mask  [3];
    logic [3:0] err0;
    logic [3:0] err1;
    logic [2:0] err2;
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
    logic [2:0] fvec0, fvec1, fvec2;
    logic       fvld  [3];
`endif

    // Truth table of f = a ? (b & c) : c, indexed by {a,b,c}.
    logic [7:0] ref_tbl = 8'b1000_1010;

    int P_S [3] = '{1, 1, 3};
    int P_P [3] = '{1, 2, 1};
    int P_W [3] = '{4, 4, 3};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign f[0] = ref_tbl[{a[0], b[0], c[0]}] ^ mask[0][{a[0], b[0], c[0]}];
    assign f[1] = ref_tbl[{a[1], b[1], c[1]}] ^ mask[1][{a[1], b[1], c[1]}];
    assign f[2] = ref_tbl[{a[2], b[2], c[2]}] ^ mask[2][{a[2], b[2], c[2]}];

    gated_and_tester #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(4)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(st[0]),
        .o_dut_a(a[0]), .o_dut_b(b[0]), .o_dut_c(c[0]), .i_dut_f(f[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_err_cnt(err0)
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
        , .o_fail_vec(fvec0), .o_fail_vld(fvld[0])
`endif
    );

    gated_and_tester #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(st[1]),
        .o_dut_a(a[1]), .o_dut_b(b[1]), .o_dut_c(c[1]), .i_dut_f(f[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_err_cnt(err1)
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
        , .o_fail_vec(fvec1), .o_fail_vld(fvld[1])
`endif
    );

    gated_and_tester #(.SETTLE_CYCLES(3), .PASSES(1), .ERR_W(3)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(st[2]),
        .o_dut_a(a[2]), .o_dut_b(b[2]), .o_dut_c(c[2]), .i_dut_f(f[2]),
        .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]), .o_err_cnt(err2)
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
        , .o_fail_vec(fvec2), .o_fail_vld(fvld[2])
`endif
    );

    function automatic int cur_vec(input int w);
        return int'({a[w], b[w], c[w]});
    endfunction

    function automatic int get_err(input int w);
        case (w)
            0:       return int'(err0);
            1:       return int'(err1);
            default: return int'(err2);
        endcase
    endfunction

`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
    function automatic int get_fvec(input int w);
        case (w)
            0:       return int'(fvec0);
            1:       return int'(fvec1);
            default: return int'(fvec2);
        endcase
    endfunction
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outcome of one run from the fault mask alone.
    task automatic model(input int w, input logic [7:0] m, output int e_err, output int e_pass,
                         output int e_fvld, output int e_fvec, output int e_lat);
        int n;
        int sat;
        n      = 0;
        e_fvld = 0;
        e_fvec = 0;
        for (int v = 7; v >= 0; v--) begin
            if (m[v]) begin
                e_fvec = v;
                e_fvld = 1;
                n++;
            end
        end
        n      = n * P_P[w];
        sat    = (1 << P_W[w]) - 1;
        e_err  = (n > sat) ? sat : n;
        e_pass = (n == 0) ? 1 : 0;
        e_lat  = 8 * P_P[w] * (P_S[w] + 1);
    endtask

    // One complete run on instance w with fault mask m, checked end to end.
    task automatic run_check(input int w, input logic [7:0] m, input int e_err, input int e_pass,
                             input int e_fvld, input int e_fvec, input int e_lat);
        int lat;
        int total;
        mask[w] = m;
        total   = 8 * P_P[w] * (P_S[w] + 1);
        st[w]   = 1'b1;
        step();
        st[w]   = 1'b0;
        lat     = 0;
        chk("busy_after_start", busy[w], 1);
        chk("err_cleared_on_start", get_err(w), 0);
        while (done[w] !== 1'b1 && lat < total + 20) begin
            if (lat < total) chk("vec_seq", cur_vec(w), (lat / (P_S[w] + 1)) % 8);
            step();
            lat++;
        end
        chk("done_latency", lat, e_lat);
        chk("err_cnt", get_err(w), e_err);
        chk("pass", pass[w], e_pass);
        chk("busy_in_done", busy[w], 1);
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
        chk("fail_vld", fvld[w], e_fvld);
        if (e_fvld != 0) chk("fail_vec", get_fvec(w), e_fvec);
`endif
        step();
        chk("done_one_cycle", done[w], 0);
        chk("busy_cleared", busy[w], 0);
        chk("vec_idle_zero", cur_vec(w), 0);
        chk("pass_held", pass[w], e_pass);
        chk("err_held", get_err(w), e_err);
    endtask

    typedef struct {
        int         w;
        logic [7:0] m;
        int         err;
        int         pss;
        int         fvld;
        int         fvec;
        int         lat;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int ndone;
        int first_done;
        int second_done;
        int e_err, e_pass, e_fvld, e_fvec, e_lat;

        tbl[0] = '{0, 8'h00,  0, 1, 0, 0, 16};
        tbl[1] = '{0, 8'h8A,  3, 0, 1, 1, 16};
        tbl[2] = '{0, 8'h75,  5, 0, 1, 0, 16};
        tbl[3] = '{1, 8'h75, 10, 0, 1, 0, 32};
        tbl[4] = '{2, 8'hFF,  7, 0, 1, 0, 32};
        tbl[5] = '{1, 8'h00,  0, 1, 0, 0, 32};
        tbl[6] = '{2, 8'h8A,  3, 0, 1, 1, 32};

        for (int i = 0; i < 3; i++) begin
            st[i]   = 1'b0;
            mask[i] = 8'h00;
        end

        // Reset values.
        rst = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_vec", cur_vec(i), 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_pass", pass[i], 0);
            chk("rst_err", get_err(i), 0);
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
            chk("rst_fvld", fvld[i], 0);
            chk("rst_fvec", get_fvec(i), 0);
`endif
        end
        rst = 1'b0;
        step();

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_check(tbl[i].w, tbl[i].m, tbl[i].err, tbl[i].pss, tbl[i].fvld, tbl[i].fvec, tbl[i].lat);
            step();
        end

        // Start pulses while busy, including one during the DONE cycle.
        mask[0] = 8'h8A;
        st[0]   = 1'b1;
        step();
        st[0]   = 1'b0;
        ndone   = 0;
        for (int k = 1; k <= 24; k++) begin
            st[0] = (k == 4 || k == 10 || k == 17) ? 1'b1 : 1'b0;
            step();
            st[0] = 1'b0;
            if (done[0] === 1'b1) begin
                ndone++;
                chk("ignore_start_done_edge", k, 16);
            end
        end
        chk("ignore_start_ndone", ndone, 1);
        chk("ignore_start_err", get_err(0), 3);
        chk("ignore_start_idle", busy[0], 0);

        // Start held high: back-to-back runs, err_cnt cleared in between.
        step();
        st[0]       = 1'b1;
        step();
        first_done  = -1;
        second_done = -1;
        for (int k = 1; k <= 35; k++) begin
            step();
            if (done[0] === 1'b1) begin
                if (first_done < 0) first_done = k;
                else second_done = k;
            end
            if (k == 17) chk("held_idle_gap_busy", busy[0], 0);
            if (k == 18) begin
                chk("held_restart_busy", busy[0], 1);
                chk("held_restart_err_clr", get_err(0), 0);
            end
        end
        st[0] = 1'b0;
        chk("held_first_done", first_done, 16);
        chk("held_second_done", second_done, 34);
        chk("held_second_err", get_err(0), 3);
        step();
        chk("held_stop_busy", busy[0], 0);

        // Reset during vector 4, then a clean run.
        step();
        mask[0] = 8'h8A;
        st[0]   = 1'b1;
        step();
        st[0]   = 1'b0;
        repeat (8) step();
        chk("pre_rst_vec", cur_vec(0), 4);
        chk("pre_rst_err", get_err(0), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_vec", cur_vec(0), 0);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_done", done[0], 0);
        chk("midrst_pass", pass[0], 0);
        chk("midrst_err", get_err(0), 0);
`ifdef GATED_AND_TESTER_FAIL_CAPTURE_EN
        chk("midrst_fvld", fvld[0], 0);
        chk("midrst_fvec", get_fvec(0), 0);
`endif
        ndone = 0;
        repeat (40) begin
            step();
            if (done[0] === 1'b1) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        run_check(0, 8'h00, 0, 1, 0, 0, 16);
        step();

        // Randomized fault masks against the behavioural model.
        for (int i = 0; i < 10; i++) begin
            int w;
            logic [7:0] m;
            w = int'($urandom_range(0, 2));
            m = 8'($urandom);
            if (i == 0) m = 8'h80;
            model(w, m, e_err, e_pass, e_fvld, e_fvec, e_lat);
            run_check(w, m, e_err, e_pass, e_fvld, e_fvec, e_lat);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
